wfg_stim_mem_streamer: RTL and testbench

//  Pattern-memory read engine for the waveform generator. Walks a programmable address window of the
//  32x512 pattern SRAM read port (csb1/addr1/dout1), prefetches words into a small FIFO, and presents

---
 rtl/wfg_stim_mem_streamer_pkg.sv | 15 +
 rtl/wfg_stim_mem_streamer_if.sv | 29 ++
 rtl/wfg_stim_mem_fifo.sv | 59 +++++
 rtl/wfg_stim_mem_streamer.sv | 121 ++++++++++++
 tb/tb_wfg_stim_mem_streamer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wfg_stim_mem_streamer_pkg.sv
// Shared definitions for the waveform-generator pattern-memory streamer.
//   WFG_MEM_ADDR_W / WFG_MEM_DATA_W : geometry of the 32x512 pattern SRAM
//   wfg_state_e                     : streamer FSM states (idle, fetch, drain)
package wfg_stim_mem_streamer_pkg;

    localparam int unsigned WFG_MEM_ADDR_W = 9;
    localparam int unsigned WFG_MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } wfg_state_e;

endpackage

// File: rtl/wfg_stim_mem_streamer_if.sv
// Bus bundle between the streamer, the pattern SRAM read port and the drive cores.
//   csb1/addr1/dout1                     : SRAM port-1 (chip select active low, 1-cycle read)
//   stim_tdata/stim_tvalid/stim_tready   : sample stream (transfer = tvalid & tready)
// Modports: master = streamer side, slave = SRAM model / sample consumer side.
interface wfg_stim_mem_streamer_if
    import wfg_stim_mem_streamer_pkg::*;
#(
    parameter int unsigned ADDR_W = WFG_MEM_ADDR_W,
    parameter int unsigned DATA_W = WFG_MEM_DATA_W
);

    logic              csb1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] dout1;
    logic [DATA_W-1:0] stim_tdata;
    logic              stim_tvalid;
    logic              stim_tready;

    modport master (
        output csb1, addr1, stim_tdata, stim_tvalid,
        input  dout1, stim_tready
    );

    modport slave (
        input  csb1, addr1, stim_tdata, stim_tvalid,
        output dout1, stim_tready
    );

endinterface

// File: rtl/wfg_stim_mem_fifo.sv
// Synchronous prefetch FIFO for the pattern streamer.
//   clk_i, rst_i (sync, active high), flush_i (sync empty, keeps storage)
//   push_i/data_i write side, pop_i read side, data_o = head (register array read)
//   count_o occupancy, empty_o / full_o flags
// A push while full is accepted only together with a pop.
module wfg_stim_mem_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wfg_stim_mem_streamer.sv
// Pattern-memory read engine: walks an address window of the pattern SRAM, prefetches
// words into a small FIFO and presents them as a valid/ready sample stream.
//   io_wbs_clk, io_wbs_rst (sync, active high)
//   ctrl_en_i (rising edge starts, low aborts), ctrl_loop_i, ctrl_start_addr_i,
//   ctrl_end_addr_i (inclusive) : sampled when a pass starts
//   bus_io (master)             : SRAM port-1 and sample stream
//   status_busy_o (fetch/drain), status_done_o (1-cycle pulse at end of one-shot pass)
module wfg_stim_mem_streamer
    import wfg_stim_mem_streamer_pkg::*;
#(
    parameter int unsigned ADDR_W     = WFG_MEM_ADDR_W,
    parameter int unsigned DATA_W     = WFG_MEM_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       io_wbs_clk,
    input  logic                       io_wbs_rst,
    input  logic                       ctrl_en_i,
    input  logic                       ctrl_loop_i,
    input  logic [ADDR_W-1:0]          ctrl_start_addr_i,
    input  logic [ADDR_W-1:0]          ctrl_end_addr_i,
    wfg_stim_mem_streamer_if.master    bus_io,
    output logic                       status_busy_o,
    output logic                       status_done_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    wfg_state_e        state_q;
    logic [ADDR_W-1:0] ptr_q, start_q, end_q;
    logic              loop_q, in_flight_q, en_q;

    logic [CntW-1:0]   fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic              credit_ok, issue, drain_done;

    // Buffered words plus the outstanding read may never exceed the FIFO depth,
    // so a returning read always has a slot.
    assign credit_ok  = (int'(fifo_count) + int'(in_flight_q)) < int'(FIFO_DEPTH);
    assign issue      = (state_q == StFetch) & ctrl_en_i & credit_ok & ~fifo_full;
    assign drain_done = (state_q == StDrain) & ctrl_en_i & fifo_empty & ~in_flight_q;

    // Read data returns one cycle after issue; an abort discards it.
    assign fifo_push  = in_flight_q & ctrl_en_i;
    assign fifo_pop   = ~fifo_empty & bus_io.stim_tready;

    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            start_q     <= '0;
            end_q       <= '0;
            loop_q      <= 1'b0;
            in_flight_q <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            en_q        <= ctrl_en_i;
            in_flight_q <= issue;
            if (!ctrl_en_i) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // Only a fresh 0->1 edge starts a pass.
                        if (!en_q) begin
                            state_q <= StFetch;
                            start_q <= ctrl_start_addr_i;
                            end_q   <= ctrl_end_addr_i;
                            loop_q  <= ctrl_loop_i;
                            ptr_q   <= ctrl_start_addr_i;
                        end
                    end
                    StFetch: begin
                        if (issue) begin
                            if (ptr_q == end_q) begin
                                if (loop_q) begin
                                    ptr_q <= start_q;
                                end else begin
                                    state_q <= StDrain;
                                end
                            end else begin
                                ptr_q <= ptr_q + ADDR_W'(1);
                            end
                        end
                    end
                    StDrain: begin
                        if (drain_done) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    wfg_stim_mem_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk_i   (io_wbs_clk),
        .rst_i   (io_wbs_rst),
        .flush_i (~ctrl_en_i),
        .push_i  (fifo_push),
        .data_i  (bus_io.dout1),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus_io.csb1        = ~issue;
    assign bus_io.addr1       = ptr_q;
    assign bus_io.stim_tvalid = ~fifo_empty;
    assign bus_io.stim_tdata  = fifo_head;

    assign status_busy_o = (state_q != StIdle);
    assign status_done_o = drain_done;

endmodule

// File: tb/tb_wfg_stim_mem_streamer.sv
// Bench for wfg_stim_mem_streamer: SRAM model, window/sample model built from
// address arithmetic, a per-cycle compare process and directed scenarios.
module tb_wfg_stim_mem_streamer;
    import wfg_stim_mem_streamer_pkg::*;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          loop_m = 1'b0;
    logic [AW-1:0] start_a = '0;
    logic [AW-1:0] end_a = '0;
    logic          busy, done;

    wfg_stim_mem_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    wfg_stim_mem_streamer #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .io_wbs_clk        (clk),
        .io_wbs_rst        (rst),
        .ctrl_en_i         (en),
        .ctrl_loop_i       (loop_m),
        .ctrl_start_addr_i (start_a),
        .ctrl_end_addr_i   (end_a),
        .bus_io            (bus),
        .status_busy_o     (busy),
        .status_done_o     (done)
    );

    always #5 clk = ~clk;

    // SRAM port-1 model: one-cycle read latency.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (!bus.csb1) bus.dout1 <= mem[bus.addr1];
    end

    // Single driver for tready, updated 2 time units after each rising edge.
    logic rand_ready = 1'b0;
    logic ready_fix  = 1'b1;
    initial begin
        bus.stim_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.stim_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model state: expected read addresses and samples, plus observation logs.
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] iss_log  [$];
    int            iss_cyc  [$];
    logic [DW-1:0] acc_log  [$];
    int            xfer_cnt = 0;
    int            done_cnt = 0;
    int            cyc      = 0;

    task automatic model_arm(input logic [AW-1:0] s, input logic [AW-1:0] e, input int copies);
        int n;
        logic [AW-1:0] a;
        n = ((int'(e) - int'(s) + (1 << AW)) % (1 << AW)) + 1;
        exp_addr.delete();
        exp_data.delete();
        iss_log.delete();
        iss_cyc.delete();
        acc_log.delete();
        xfer_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < copies; c++) begin
            for (int i = 0; i < n; i++) begin
                a = AW'((int'(s) + i) % (1 << AW));
                exp_addr.push_back(a);
                exp_data.push_back(mem[a]);
            end
        end
    endtask

    // Compare process: runs every falling edge.
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!bus.csb1) begin
                iss_log.push_back(bus.addr1);
                iss_cyc.push_back(cyc);
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL read_addr: got read at %0h, expected no read", bus.addr1);
                end else begin
                    check("read_addr", 64'(bus.addr1), 64'(exp_addr.pop_front()));
                end
            end
            if (prev_hold && bus.stim_tvalid) begin
                check("tdata_hold", 64'(bus.stim_tdata), 64'(prev_data));
            end
            if (bus.stim_tvalid && bus.stim_tready) begin
                acc_log.push_back(bus.stim_tdata);
                xfer_cnt++;
                if (exp_data.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sample: got %0h, expected no sample", bus.stim_tdata);
                end else begin
                    check("sample", 64'(bus.stim_tdata), 64'(exp_data.pop_front()));
                end
            end
            prev_hold = bus.stim_tvalid && !bus.stim_tready;
            prev_data = bus.stim_tdata;
            if (done) done_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic lp,
                              input int copies);
        en      = 1'b0;
        start_a = s;
        end_a   = e;
        loop_m  = lp;
        model_arm(s, e, copies);
        step(1);
        en = 1'b1;
        step(1);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (!(done_cnt > 0 && !busy) && k < budget) begin
            step(1);
            k++;
        end
        check({name, "_finished"}, 64'(k < budget), 64'(1));
        check({name, "_done_pulses"}, 64'(done_cnt), 64'(1));
        check({name, "_all_samples"}, 64'(exp_data.size()), 64'(0));
        check({name, "_all_reads"}, 64'(exp_addr.size()), 64'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_csb1"}, 64'(bus.csb1), 64'(1));
        check({name, "_addr1"}, 64'(bus.addr1), 64'(0));
        check({name, "_tvalid"}, 64'(bus.stim_tvalid), 64'(0));
        check({name, "_tdata"}, 64'(bus.stim_tdata), 64'(0));
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int x0;
        for (int i = 0; i < 2**AW; i++) mem[i] = $urandom;

        // Reset state
        rst = 1'b1;
        step(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(1);

        // 1) One-shot 0x010..0x013, tready high
        ready_fix = 1'b1;
        start_pass(9'h010, 9'h013, 1'b0, 1);
        wait_done(60, "t1");
        check("t1_nreads", 64'(iss_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) check("t1_addr_seq", 64'(iss_log[i]), 64'(9'h010 + i));
        check("t1_back_to_back", 64'(iss_cyc[3] - iss_cyc[0]), 64'(3));
        check("t1_first_sample", 64'(acc_log[0]), 64'(mem[9'h010]));
        step(5);  // en still high: no restart
        check("t1_no_restart_busy", 64'(busy), 64'(0));
        check("t1_no_restart_reads", 64'(iss_log.size()), 64'(4));

        // 2) Same window with the consumer stalled
        ready_fix = 1'b0;
        start_pass(9'h010, 9'h013, 1'b0, 1);
        step(20);
        check("t2_nreads", 64'(iss_log.size()), 64'(DEPTH));
        check("t2_csb1_idle", 64'(bus.csb1), 64'(1));
        check("t2_tvalid", 64'(bus.stim_tvalid), 64'(1));
        ready_fix = 1'b1;
        wait_done(60, "t2");
        check("t2_naccepted", 64'(acc_log.size()), 64'(4));

        // 2b) Longer window stalled: credit caps prefetch at the FIFO depth
        ready_fix = 1'b0;
        start_pass(9'h010, 9'h01F, 1'b0, 1);
        step(20);
        check("t2b_credit_cap", 64'(iss_log.size()), 64'(DEPTH));
        ready_fix = 1'b1;
        wait_done(80, "t2b");
        check("t2b_naccepted", 64'(acc_log.size()), 64'(16));

        // 3) Window wrapping through the top of the address space; controls change mid-pass
        start_pass(9'h1FE, 9'h001, 1'b0, 1);
        start_a = 9'h000;
        end_a   = 9'h1FF;
        loop_m  = 1'b1;
        wait_done(60, "t3");
        check("t3_addr0", 64'(iss_log[0]), 64'(9'h1FE));
        check("t3_addr1", 64'(iss_log[1]), 64'(9'h1FF));
        check("t3_addr2", 64'(iss_log[2]), 64'(9'h000));
        check("t3_addr3", 64'(iss_log[3]), 64'(9'h001));
        check("t3_wrap_sample", 64'(acc_log[2]), 64'(mem[0]));

        // 4) Loop mode over 3 words: 12 back-to-back transfers
        start_pass(9'h020, 9'h022, 1'b1, 10);
        k = 0;
        while (!bus.stim_tvalid && k < 20) begin
            step(1);
            k++;
        end
        check("t4_tvalid_seen", 64'(bus.stim_tvalid), 64'(1));
        x0 = xfer_cnt;
        step(12);
        check("t4_no_bubble", 64'(xfer_cnt - x0), 64'(12));
        for (int i = 0; i < 12; i++) check("t4_pattern", 64'(acc_log[i]), 64'(mem[9'h020 + i % 3]));
        check("t4_busy", 64'(busy), 64'(1));
        check("t4_no_done", 64'(done_cnt), 64'(0));
        en = 1'b0;
        #1;
        check("t4_abort_csb1", 64'(bus.csb1), 64'(1));
        step(1);
        check("t4_abort_tvalid", 64'(bus.stim_tvalid), 64'(0));
        check("t4_abort_busy", 64'(busy), 64'(0));
        check("t4_abort_no_done", 64'(done_cnt), 64'(0));

        // 5) Abort with a read in flight, then restart
        start_pass(9'h040, 9'h04F, 1'b0, 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.csb1 && k < 50);
        check("t5_read_seen", 64'(bus.csb1), 64'(0));
        @(posedge clk);
        #1;
        en = 1'b0;
        #1;
        check("t5_abort_csb1", 64'(bus.csb1), 64'(1));
        step(1);
        check("t5_tvalid", 64'(bus.stim_tvalid), 64'(0));
        check("t5_csb1", 64'(bus.csb1), 64'(1));
        check("t5_busy", 64'(busy), 64'(0));
        step(3);
        check("t5_inflight_dropped", 64'(bus.stim_tvalid), 64'(0));
        check("t5_no_done", 64'(done_cnt), 64'(0));
        start_pass(9'h040, 9'h04F, 1'b0, 1);
        wait_done(80, "t5_restart");
        check("t5_restart_addr", 64'(iss_log[0]), 64'(9'h040));
        check("t5_restart_count", 64'(acc_log.size()), 64'(16));

        // 6) Reset mid-pass under random backpressure, then a clean wrapped pass
        rand_ready = 1'b1;
        start_pass(9'h100, 9'h13F, 1'b0, 1);
        step(30);
        rst = 1'b1;
        step(1);
        check_reset_outputs("t6_reset");
        en = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        start_pass(9'h1F0, 9'h00F, 1'b0, 1);
        wait_done(600, "t6");
        check("t6_count", 64'(acc_log.size()), 64'(32));
        rand_ready = 1'b0;
        en = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
